// File: rtl/sb_tx_arbiter.sv
`default_nettype none
// ==== sb_tx_arbiter : round-robin sideband TX arbiter with pattern priority and busy timeout | rev 1.0 ====
module sb_tx_arbiter #(
  parameter int MSG_W        = 8,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pattern_req,
  input  logic [1:0]       i_req,
  input  logic [MSG_W-1:0] i_req0_msg,
  input  logic [MSG_W-1:0] i_req1_msg,
  input  logic             i_tx_busy,
  input  logic             i_start_pattern_done,
  output logic             o_start_pattern_req,
  output logic             o_msg_valid,
  output logic [MSG_W-1:0] o_msg,
  output logic [1:0]       o_grant,
  output logic [1:0]       o_done,
  output logic             o_pattern_done,
  output logic             o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PATTERN   = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_COMPLETE  = 3'd5
  } state_t;

  localparam logic [3:0] c_cnt_last = 4'(BUSY_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             err_q, err_d;
  logic             pat_done_q, pat_done_d;
  logic [1:0]       w_win;

  // ptr_q holds the index of the last winner; on contention the other side wins.
  always_comb begin
    w_win = 2'b00;
    case (i_req)
      2'b01:   w_win = 2'b01;
      2'b10:   w_win = 2'b10;
      2'b11:   w_win = ptr_q ? 2'b01 : 2'b10;
      default: w_win = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = 4'd0;
    grant_d    = grant_q;
    msg_d      = msg_q;
    err_d      = err_q;
    pat_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_pattern_req) begin
          state_d = S_PATTERN;
        end else if (|i_req) begin
          grant_d = w_win;
          msg_d   = w_win[1] ? i_req1_msg : i_req0_msg;
          state_d = S_LAUNCH;
        end
      end
      S_PATTERN: begin
        if (i_start_pattern_done) begin
          pat_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = S_WAIT_IDLE;
        end else if (cnt_q == c_cnt_last) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (!i_tx_busy) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        ptr_d   = grant_q[1];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= 4'd0;
      grant_q    <= 2'b00;
      msg_q      <= '0;
      err_q      <= 1'b0;
      pat_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      msg_q      <= msg_d;
      err_q      <= err_d;
      pat_done_q <= pat_done_d;
    end
  end

  // Strobes decode straight from state so an async reset silences them at once.
  assign o_start_pattern_req = (state_q == S_PATTERN);
  assign o_msg_valid         = (state_q == S_LAUNCH);
  assign o_done              = (state_q == S_COMPLETE) ? grant_q : 2'b00;
  assign o_msg               = msg_q;
  assign o_grant             = grant_q;
  assign o_pattern_done      = pat_done_q;
  assign o_timeout_err       = err_q;

endmodule
`default_nettype wire
